// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline.
// Drives the PC and pipeline-bank enables and clears, selects the EX-stage
// forwarding sources, runs the debug halt/single-step sequencer, and keeps
// saturating stall and flush event counters.
module pipeline_ctrl #(
  parameter int CNT_W        = 16,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic [4:0]       mem_rd,
  input  logic             mem_regwrite,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic             branch_taken,
  input  logic             dbg_halt_req,
  input  logic             dbg_step_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clr,
  output logic             idex_clr,
  output logic             exmem_clr,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             halted,
  output logic             step_ack,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_STEP} state_t;

  state_t           state_q;
  logic [DW-1:0]    drain_q;
  logic             step_flag_q;
  logic             halted_q;
  logic             step_ack_q;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             load_use;
  logic             stall_ev;

  // MEM-stage result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    if (m_we && (m_rd != 5'd0) && (m_rd == rs))      return 2'b10;
    else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) return 2'b01;
    else                                              return 2'b00;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  // Hazard detection, forwarding selects and counter next-state.
  always_comb begin
    load_use = ex_memread && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    // A taken branch flushes the stalled instruction, so the stall is moot.
    stall_ev = load_use && !branch_taken;
    fwd_a    = fwd_sel(ex_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    fwd_b    = fwd_sel(ex_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
    stall_d  = stall_ev     ? sat_inc(stall_q) : stall_q;
    flush_d  = branch_taken ? sat_inc(flush_q) : flush_q;
  end

  // Bank enables and clears: reset, then branch flush, then load-use stall, then state.
  always_comb begin
    pc_en     = 1'b0;
    ifid_en   = 1'b0;
    ifid_clr  = 1'b0;
    idex_clr  = 1'b0;
    exmem_clr = 1'b0;
    if (RESET) begin
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (branch_taken) begin
      // Still loads the PC while draining/stepping so the halt resumes at the target.
      pc_en     = 1'b1;
      ifid_en   = 1'b1;
      ifid_clr  = 1'b1;
      idex_clr  = 1'b1;
      exmem_clr = 1'b1;
    end else if (load_use) begin
      idex_clr = 1'b1;
    end else begin
      case (state_q)
        S_RUN, S_STEP: begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
        S_DRAIN: begin
          ifid_en  = 1'b1;
          ifid_clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Debug sequencer with registered halted/step_ack, plus event counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_RUN;
      drain_q     <= '0;
      step_flag_q <= 1'b0;
      halted_q    <= 1'b0;
      step_ack_q  <= 1'b0;
      stall_q     <= '0;
      flush_q     <= '0;
    end else begin
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      step_ack_q <= 1'b0;
      case (state_q)
        S_RUN: begin
          if (dbg_halt_req) begin
            state_q     <= S_DRAIN;
            drain_q     <= DW'(DRAIN_CYCLES - 1);
            step_flag_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          // Drain always completes, even if the halt request is withdrawn.
          if (drain_q == '0) begin
            state_q     <= S_HALTED;
            halted_q    <= 1'b1;
            step_ack_q  <= step_flag_q;
            step_flag_q <= 1'b0;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        S_HALTED: begin
          if (!dbg_halt_req) begin
            state_q  <= S_RUN;
            halted_q <= 1'b0;
          end else if (dbg_step_req) begin
            state_q  <= S_STEP;
            halted_q <= 1'b0;
          end
        end
        S_STEP: begin
          // The single fetch is accepted once it is not held by a load-use stall.
          if (!stall_ev) begin
            state_q     <= S_DRAIN;
            drain_q     <= DW'(DRAIN_CYCLES - 1);
            step_flag_q <= 1'b1;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  assign halted      = halted_q;
  assign step_ack    = step_ack_q;
  assign stall_count = stall_q;
  assign flush_count = flush_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (CNT_W=4 so saturation is reachable).
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  logic             CLK, RESET;
  logic [4:0]       id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic             id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite;
  logic             branch_taken, dbg_halt_req, dbg_step_req;
  logic             pc_en, ifid_en, ifid_clr, idex_clr, exmem_clr, halted, step_ack;
  logic [1:0]       fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_count, flush_count;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(4)) dut (
    .CLK(CLK), .RESET(RESET),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .dbg_halt_req(dbg_halt_req), .dbg_step_req(dbg_step_req),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clr(ifid_clr), .idex_clr(idex_clr),
    .exmem_clr(exmem_clr), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted),
    .step_ack(step_ack), .stall_count(stall_count), .flush_count(flush_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step_clk();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_hazards();
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0;
    branch_taken = 0;
  endtask

  task automatic set_load_use();
    ex_memread = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
  endtask

  // Four bubble cycles, ending in HALTED.
  task automatic drain4(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_ifid_clr"}, ifid_clr, 1);
      chk({tag, "_pc_en"}, pc_en, 0);
      chk({tag, "_halted"}, halted, 0);
      step_clk();
    end
  endtask

  initial begin
    clear_hazards();
    dbg_halt_req = 0; dbg_step_req = 0;
    RESET = 1;
    repeat (2) step_clk();

    // Reset
    chk("rst_pc_en", pc_en, 0);
    chk("rst_ifid_en", ifid_en, 0);
    chk("rst_clrs", {ifid_clr, idex_clr, exmem_clr}, 3'b111);
    chk("rst_stall", stall_count, 0);
    chk("rst_flush", flush_count, 0);
    chk("rst_halted", halted, 0);
    chk("rst_step_ack", step_ack, 0);
    RESET = 0; #1;
    chk("run_pc_en", pc_en, 1);
    chk("run_ifid_en", ifid_en, 1);
    chk("run_clrs", {ifid_clr, idex_clr, exmem_clr}, 3'b000);
    step_clk();

    // Load-use on rs1
    set_load_use(); #1;
    chk("lu_pc_en", pc_en, 0);
    chk("lu_ifid_en", ifid_en, 0);
    chk("lu_idex_clr", idex_clr, 1);
    chk("lu_ifid_clr", ifid_clr, 0);
    step_clk();
    chk("lu_stall1", stall_count, 1);
    // ex_rd = x0 never stalls, even when id_rs1 = x0
    ex_rd = 0; id_rs1 = 0; #1;
    chk("lu_x0_pc_en", pc_en, 1);
    chk("lu_x0_idex_clr", idex_clr, 0);
    step_clk();
    chk("lu_x0_stall", stall_count, 1);
    // Load-use on rs2, then same regs without use flag
    clear_hazards();
    ex_memread = 1; ex_rd = 9; id_rs2 = 9; id_use_rs2 = 1; #1;
    chk("lu_rs2_pc_en", pc_en, 0);
    step_clk();
    chk("lu_rs2_stall", stall_count, 2);
    id_use_rs2 = 0; #1;
    chk("lu_nouse_pc_en", pc_en, 1);
    step_clk();
    chk("lu_nouse_stall", stall_count, 2);
    clear_hazards();

    // Forwarding
    mem_rd = 7; wb_rd = 7; ex_rs1 = 7; mem_regwrite = 1; wb_regwrite = 1; #1;
    chk("fwd_a_mem", fwd_a, 2'b10);
    chk("fwd_b_none", fwd_b, 2'b00);
    mem_regwrite = 0; #1;
    chk("fwd_a_wb", fwd_a, 2'b01);
    mem_regwrite = 1; ex_rs1 = 0; #1;
    chk("fwd_a_x0", fwd_a, 2'b00);
    ex_rs2 = 3; wb_rd = 3; #1;
    chk("fwd_b_wb", fwd_b, 2'b01);
    mem_rd = 3; #1;
    chk("fwd_b_mem", fwd_b, 2'b10);
    mem_rd = 0; wb_rd = 0; ex_rs2 = 0; #1;
    chk("fwd_b_x0", fwd_b, 2'b00);
    step_clk();
    clear_hazards();

    // Branch overrides load-use
    set_load_use(); branch_taken = 1; #1;
    chk("br_pc_en", pc_en, 1);
    chk("br_ifid_en", ifid_en, 1);
    chk("br_clrs", {ifid_clr, idex_clr, exmem_clr}, 3'b111);
    step_clk();
    chk("br_flush", flush_count, 1);
    chk("br_stall", stall_count, 2);
    clear_hazards();

    // Halt
    dbg_halt_req = 1; #1;
    chk("halt_req_pc_en", pc_en, 1);
    step_clk();
    drain4("drain");
    chk("halted", halted, 1);
    chk("halted_pc_en", pc_en, 0);
    chk("halted_ifid_en", ifid_en, 0);
    chk("halted_clrs", {ifid_clr, idex_clr, exmem_clr}, 3'b000);
    chk("halted_no_ack", step_ack, 0);
    step_clk();
    chk("halted_hold", halted, 1);

    // Single step
    dbg_step_req = 1; #1;
    chk("step_req_pc_en", pc_en, 0);
    step_clk();
    dbg_step_req = 0; #1;
    chk("step_pc_en", pc_en, 1);
    chk("step_ifid_en", ifid_en, 1);
    chk("step_halted", halted, 0);
    step_clk();
    drain4("step_drain");
    chk("step_halted_end", halted, 1);
    chk("step_ack", step_ack, 1);
    step_clk();
    chk("step_ack_pulse", step_ack, 0);
    chk("step_halted_hold", halted, 1);

    // Single step held by a load-use stall
    dbg_step_req = 1;
    step_clk();
    dbg_step_req = 0; set_load_use(); #1;
    chk("stepstall_pc_en", pc_en, 0);
    chk("stepstall_halted", halted, 0);
    step_clk();
    clear_hazards(); #1;
    chk("stepstall_release_pc_en", pc_en, 1);
    chk("stepstall_count", stall_count, 3);
    step_clk();
    drain4("stepstall_drain");
    chk("stepstall_halted_end", halted, 1);
    chk("stepstall_ack", step_ack, 1);

    // Release halt
    dbg_halt_req = 0; #1;
    chk("release_still_halted", halted, 1);
    step_clk();
    chk("release_halted", halted, 0);
    chk("release_pc_en", pc_en, 1);

    // Halt withdrawn mid-drain, with a branch in the first drain cycle
    dbg_halt_req = 1;
    step_clk();
    dbg_halt_req = 0; branch_taken = 1; #1;
    chk("drain_br_pc_en", pc_en, 1);
    chk("drain_br_exmem_clr", exmem_clr, 1);
    step_clk();
    branch_taken = 0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_drain_ifid_clr", ifid_clr, 1);
      step_clk();
    end
    chk("drop_halted", halted, 1);
    step_clk();
    chk("drop_run_halted", halted, 0);
    chk("drop_run_pc_en", pc_en, 1);
    chk("drop_flush", flush_count, 2);

    // Stall counter saturation
    set_load_use();
    repeat (20) step_clk();
    chk("sat_stall", stall_count, 15);
    step_clk();
    chk("sat_stall_hold", stall_count, 15);
    chk("sat_flush", flush_count, 2);
    clear_hazards();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
